i2c_target: RTL and testbench



---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_sync.sv | 46 ++++
 rtl/i2c_target.sv | 172 +++++++++++++++++
 tb/tb_i2c_target.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared state encoding and bus constants for the I2C target.
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h40;
  localparam logic       RW_WRITE         = 1'b0;
  localparam logic       RW_READ          = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk_i and derives SCL edges plus START/STOP events.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Idle bus is high; resetting to 1 avoids spurious edges after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda    = r_sda_sync[SYNC_STAGES-1];
  assign scl_rise = w_scl & ~r_scl_d;
  assign scl_fall = ~w_scl & r_scl_d;
  assign start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
  assign stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;
  assign sda_s    = w_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target bridging bus transfers to a register bank (pointer + data bytes).
// Define I2C_TARGET_AUTOINC_EN to advance the pointer after each data byte.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDRESS = I2C_DEFAULT_ADDR,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam logic [7:0] PTR_STEP = 8'd1;
`else
  localparam logic [7:0] PTR_STEP = 8'd0;
`endif

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_sda;
  logic [7:0] w_byte;
  logic       w_last_bit;

  i2c_state_e r_state;
  logic [3:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [7:0] r_tx;
  logic [7:0] r_ptr;
  logic [7:0] r_wdata;
  logic       r_oe;
  logic       r_we;
  logic       r_busy;
  logic       r_rw;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .scl_rise(w_scl_rise),
    .scl_fall(w_scl_fall),
    .start   (w_start),
    .stop    (w_stop),
    .sda_s   (w_sda)
  );

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_last_bit = (r_bitcnt == 4'd7);

  // Receive states count SCL rises 0..7; ACK slots use 8 (before 9th rise) and 9 (after).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tx     <= '0;
      r_ptr    <= '0;
      r_wdata  <= '0;
      r_oe     <= 1'b0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_rw     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_we) r_ptr <= r_ptr + PTR_STEP;
      if (w_start) begin
        r_state  <= ST_ADDR;
        r_bitcnt <= '0;
        r_oe     <= 1'b0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_bitcnt <= '0;
        r_oe     <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              if (!w_last_bit) begin
                r_bitcnt <= r_bitcnt + 4'd1;
              end else begin
                r_bitcnt <= 4'd8;
                if (r_state == ST_ADDR) begin
                  r_rw <= w_sda;
                  if (w_byte[7:1] == TARGET_ADDRESS) begin
                    r_state <= ST_ADDR_ACK;
                    r_busy  <= 1'b1;
                  end else begin
                    r_state <= ST_IGNORE;
                    r_busy  <= 1'b0;
                  end
                end else if (r_state == ST_PTR) begin
                  r_ptr   <= w_byte;
                  r_state <= ST_PTR_ACK;
                end else begin
                  r_wdata <= w_byte;
                  r_we    <= 1'b1;
                  r_state <= ST_WDATA_ACK;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_rise && r_bitcnt == 4'd8) begin
              r_bitcnt <= 4'd9;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_oe <= 1'b1;
            end else if (w_scl_fall && r_bitcnt == 4'd9) begin
              r_bitcnt <= '0;
              if (r_state == ST_ADDR_ACK && r_rw == RW_READ) begin
                r_tx    <= reg_rdata_i;
                r_oe    <= ~reg_rdata_i[7];
                r_state <= ST_RDATA;
              end else begin
                r_oe    <= 1'b0;
                r_state <= (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall && r_bitcnt != 4'd0) begin
              if (r_bitcnt == 4'd8) begin
                r_oe    <= 1'b0;
                r_state <= ST_RDATA_ACK;
              end else begin
                r_tx <= {r_tx[6:0], 1'b0};
                r_oe <= ~r_tx[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (w_scl_rise && r_bitcnt == 4'd8) begin
              r_ptr    <= r_ptr + PTR_STEP;
              r_bitcnt <= 4'd9;
              if (w_sda) r_state <= ST_IGNORE;
            end else if (w_scl_fall && r_bitcnt == 4'd9) begin
              r_tx     <= reg_rdata_i;
              r_oe     <= ~reg_rdata_i[7];
              r_bitcnt <= '0;
              r_state  <= ST_RDATA;
            end
          end
          ST_IDLE, ST_IGNORE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda_oe_o    = r_oe;
  assign reg_addr_o  = r_ptr;
  assign reg_wdata_o = r_wdata;
  assign reg_we_o    = r_we;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C controller driving i2c_target against a transaction-level model.
module tb_i2c_target;

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int Q = 5;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] raddr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
  logic       busy;

  always #5 clk = ~clk;

  assign sda_bus = m_sda & ~sda_oe;
  assign rdata   = raddr ^ 8'h5A;

  i2c_target #(
    .TARGET_ADDRESS(7'h40),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scl_i      (m_scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe),
    .reg_addr_o (raddr),
    .reg_wdata_o(wdata),
    .reg_we_o   (we),
    .reg_rdata_i(rdata),
    .busy_o     (busy)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_wr[$];
  logic [15:0] last_wr = '0;
  int          oe_cycles = 0;
  logic [7:0]  m_ptr = '0;
  bit          m_addressed = 1'b0;
  bit          m_read = 1'b0;
  bit          m_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic prev_we = 1'b0, prev_scl = 1'b1, prev_oe = 1'b0;
  logic [15:0] e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sda_oe) oe_cycles++;
      if (we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual=%02h:%02h expected=none", raddr, wdata);
        end else begin
          e = exp_wr.pop_front();
          if ({raddr, wdata} !== e) begin
            failures++;
            $display("FAIL write_event actual=%04h expected=%04h", {raddr, wdata}, e);
          end
        end
        last_wr = {raddr, wdata};
        checks++;
        if (prev_we) begin
          failures++;
          $display("FAIL we_width actual=2+ expected=1");
        end
      end
      if (m_scl && prev_scl) begin
        checks++;
        if (sda_oe !== prev_oe) begin
          failures++;
          $display("FAIL oe_stable_scl_high actual=%0b expected=%0b", sda_oe, prev_oe);
        end
      end
    end
    prev_we  = we;
    prev_scl = m_scl;
    prev_oe  = sda_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b0; tick(H);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); m_sda = b;
    tick(Q); m_scl = 1'b1;
    tick(H); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(2); m_sda = 1'b1;
    tick(2*Q-2); m_scl = 1'b1;
    tick(H/2); b = sda_bus;
    tick(H/2); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic bi;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(bi);
    ack = ~bi;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic bi;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bi);
      d[i] = bi;
    end
    send_bit(~mack);
  endtask

  task automatic tx_addr(input logic [7:0] b);
    logic ack;
    m_addressed = (b[7:1] == 7'h40);
    m_read      = b[0];
    m_first     = 1'b1;
    write_byte(b, ack);
    check("addr_ack", ack, m_addressed);
    if (m_addressed) check("busy_addressed", busy, 1);
  endtask

  task automatic tx_wbyte(input logic [7:0] d);
    logic ack;
    if (m_addressed && !m_read) begin
      if (m_first) m_ptr = d;
      else begin
        exp_wr.push_back({m_ptr, d});
        if (AUTOINC) m_ptr = m_ptr + 8'd1;
      end
    end
    m_first = 1'b0;
    write_byte(d, ack);
    check("data_ack", ack, m_addressed && !m_read);
  endtask

  task automatic tx_rbyte(input logic mack, output logic [7:0] d);
    logic [7:0] expd;
    expd = m_ptr ^ 8'h5A;
    read_byte(d, mack);
    check("read_byte", d, expd);
    if (AUTOINC) m_ptr = m_ptr + 8'd1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [6:0] a;
    logic       rw;
    int         n;
    int         oe0;

    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_addr", raddr, 0);
    check("rst_reg_wdata", wdata, 0);
    check("rst_reg_we", we, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);

    // single write
    i2c_start(); tx_addr(8'h80); tx_wbyte(8'h06); tx_wbyte(8'hA5);
    check("busy_mid", busy, 1);
    i2c_stop();
    check("busy_after_stop", busy, 0);
    check("write_lit", last_wr, 16'h06A5);
    check("ptr_after_write", raddr, AUTOINC ? 8'h07 : 8'h06);
    check("wr_queue_drained", exp_wr.size(), 0);

    // burst write
    i2c_start(); tx_addr(8'h80); tx_wbyte(8'h06); tx_wbyte(8'h11); tx_wbyte(8'h22); i2c_stop();
    check("burst_lit", last_wr, AUTOINC ? 16'h0722 : 16'h0622);
    check("wr_queue_drained", exp_wr.size(), 0);

    // read with repeated start, ACK then NACK
    i2c_start(); tx_addr(8'h80); tx_wbyte(8'hFE);
    i2c_start(); tx_addr(8'h81);
    tx_rbyte(1'b1, d); check("read_lit0", d, 8'hA4);
    tx_rbyte(1'b0, d); check("read_lit1", d, AUTOINC ? 8'hA5 : 8'hA4);
    i2c_stop();
    check("ptr_after_read", raddr, AUTOINC ? 8'h00 : 8'hFE);
    check("busy_after_read", busy, 0);

    // foreign address
    oe0 = oe_cycles;
    i2c_start(); tx_addr(8'h84); tx_wbyte(8'h12); tx_wbyte(8'h34); i2c_stop();
    check("mismatch_no_oe", oe_cycles - oe0, 0);
    check("mismatch_busy", busy, 0);

    // STOP in the middle of a data byte
    i2c_start(); tx_addr(8'h80); tx_wbyte(8'h06);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    check("abort_busy", busy, 0);
    i2c_start(); tx_addr(8'h80); tx_wbyte(8'h06); tx_wbyte(8'h33); i2c_stop();
    check("after_abort_lit", last_wr, 16'h0633);

    // reset while driving a read bit (0x10 ^ 0x5A = 0x4A, MSB 0 -> SDA pulled)
    i2c_start(); tx_addr(8'h80); tx_wbyte(8'h10);
    i2c_start(); tx_addr(8'h81);
    tick(6);
    check("rdata_driving", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_oe", sda_oe, 0);
    check("async_rst_addr", raddr, 0);
    check("async_rst_busy", busy, 0);
    m_sda = 1'b1; tick(2);
    m_scl = 1'b1; tick(4);
    rst_n = 1'b1; tick(4);
    m_ptr = '0; m_addressed = 1'b0;
    i2c_start(); tx_addr(8'h80); tx_wbyte(8'h09); tx_wbyte(8'h77); i2c_stop();
    check("post_reset_lit", last_wr, 16'h0977);

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h40;
      rw = 1'($urandom);
      i2c_start();
      tx_addr({a, rw});
      if (!rw) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) tx_wbyte(8'($urandom));
      end else if (m_addressed) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) tx_rbyte(k != n - 1, d);
      end
      i2c_stop();
      check("rand_ptr", raddr, m_ptr);
      check("rand_busy", busy, 0);
      check("rand_wr_drained", exp_wr.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
